// File: rtl/load_unit_pkg.sv
// Shared definitions for the load path: ld_size encodings, controller
// states and the byte-lane index width.
package load_unit_pkg;
  localparam int LANE_BITS = 2;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;  // 2'b11 is reserved and behaves as a word

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
endpackage

// File: rtl/load_unit_extract.sv
// load_extract: combinational byte-lane select and sign/zero extension.
//   rdata     : 32-bit memory word
//   lane      : byte offset inside the word (addr[1:0])
//   size      : ld_size encoding (byte/half/word, reserved = word)
//   is_signed : 1 = replicate the field MSB, 0 = zero pad
//   data      : extended result
module load_extract
  import load_unit_pkg::*;
(
  input  logic [31:0]          rdata,
  input  logic [LANE_BITS-1:0] lane,
  input  logic [1:0]           size,
  input  logic                 is_signed,
  output logic [31:0]          data
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b    = rdata[8*lane +: 8];
    // halves select on lane[1] only, so an odd half address falls onto its half
    h    = rdata[16*lane[1] +: 16];
    data = rdata;
    case (size)
      SIZE_BYTE: data = {{24{is_signed & b[7]}}, b};
      SIZE_HALF: data = {{16{is_signed & h[15]}}, h};
      default:   data = rdata;
    endcase
  end
endmodule

// File: rtl/load_unit.sv
// load_unit: multi-cycle data-memory read controller for the load path.
// One request at a time: accept on ld_valid/ld_ready, issue one word-aligned
// read (mem_re for a single cycle), wait MEM_LATENCY cycles, extract and
// extend the addressed field, then hold it on rd_valid/rd_ready.
//   clk, reset          : clock, synchronous active-high reset
//   ld_valid/ld_ready   : request handshake; ld_addr, ld_size, ld_signed
//   mem_re/mem_addr     : read strobe and word-aligned address; mem_rdata in
//   rd_valid/rd_ready   : result handshake; rd_data, rd_err out
// Optional macro LOAD_UNIT_ALIGN_CHECK_EN: misaligned half/word requests
// skip the memory access and complete with rd_err=1, rd_data=0.
module load_unit
  import load_unit_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [1:0]            ld_size,
  input  logic                  ld_signed,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_err
);
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  state_t               st;
  logic [CW-1:0]        cnt;
  logic [LANE_BITS-1:0] a_lane;
  logic [1:0]           a_size;
  logic                 a_sgn;
  logic [31:0]          ext;
  logic                 accept;

  assign accept = ld_valid && ld_ready;

  load_extract u_extract (
    .rdata     (mem_rdata),
    .lane      (a_lane),
    .size      (a_size),
    .is_signed (a_sgn),
    .data      (ext)
  );

`ifdef LOAD_UNIT_ALIGN_CHECK_EN
  logic misal;
  always_comb begin
    misal = 1'b0;
    case (ld_size)
      SIZE_BYTE: misal = 1'b0;
      SIZE_HALF: misal = ld_addr[0];
      default:   misal = (ld_addr[1:0] != 2'b00);
    endcase
  end
  logic err_q;
  assign rd_err = err_q;
`else
  assign rd_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= IDLE;
      cnt      <= '0;
      a_lane   <= '0;
      a_size   <= SIZE_BYTE;
      a_sgn    <= 1'b0;
      ld_ready <= 1'b1;
      mem_re   <= 1'b0;
      mem_addr <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
`ifdef LOAD_UNIT_ALIGN_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      case (st)
        IDLE: if (accept) begin
          a_lane   <= ld_addr[LANE_BITS-1:0];
          a_size   <= ld_size;
          a_sgn    <= ld_signed;
          ld_ready <= 1'b0;
`ifdef LOAD_UNIT_ALIGN_CHECK_EN
          if (misal) begin
            // no memory access: complete immediately with an error
            rd_data  <= '0;
            err_q    <= 1'b1;
            rd_valid <= 1'b1;
            st       <= DONE;
          end else begin
            err_q    <= 1'b0;
            mem_addr <= {ld_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_re   <= 1'b1;
            st       <= REQ;
          end
`else
          mem_addr <= {ld_addr[ADDR_WIDTH-1:2], 2'b00};
          mem_re   <= 1'b1;
          st       <= REQ;
`endif
        end
        REQ: begin
          mem_re <= 1'b0;
          cnt    <= CW'(MEM_LATENCY - 1);
          st     <= WAIT;
        end
        WAIT: begin
          // cnt==0 marks the one cycle in which mem_rdata belongs to us
          if (cnt == '0) begin
            rd_data  <= ext;
            rd_valid <= 1'b1;
            st       <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: if (rd_ready) begin
          rd_valid <= 1'b0;
          ld_ready <= 1'b1;
          st       <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule
